// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle 16-bit shifter/rotator that reuses one
// shift stage for the 1/2/4/8 passes selected by the amount bits.
module shift_seq_ctrl #(
    parameter int SKIP_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_cnt,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] data_q, data_nxt;
    logic [3:0]  cnt_q, cnt_nxt;
    logic [1:0]  op_q, op_nxt;
    logic [1:0]  k_q, k_nxt;

    logic [3:0]  amt;
    logic [31:0] dbl;
    logic [15:0] stage_out;
    logic        hi_zero;
    logic        last_pass;

    // Shared shift stage: one pass of the held data by 2^k.
    always_comb begin
        amt = 4'd1 << k_q;
        dbl = {data_q, data_q} << amt;
        unique case (op_q)
            OP_ROL:  stage_out = dbl[31:16];
            OP_SLL:  stage_out = data_q << amt;
            OP_SRA:  stage_out = $unsigned($signed(data_q) >>> amt);
            default: stage_out = data_q >> amt;
        endcase
    end

    // Last pass: k = 3, or (early exit) no amount bits remain above k.
    always_comb begin
        unique case (k_q)
            2'd0:    hi_zero = (cnt_q[3:1] == 3'd0);
            2'd1:    hi_zero = (cnt_q[3:2] == 2'd0);
            2'd2:    hi_zero = !cnt_q[3];
            default: hi_zero = 1'b1;
        endcase
        last_pass = (k_q == 2'd3) || ((SKIP_ZERO != 0) && hi_zero);
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        cnt_nxt   = cnt_q;
        op_nxt    = op_q;
        k_nxt     = k_q;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    data_nxt  = in_data;
                    cnt_nxt   = in_cnt;
                    op_nxt    = in_op;
                    k_nxt     = 2'd0;
                    state_nxt = (in_cnt == 4'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q[k_q]) begin
                    data_nxt = stage_out;
                end
                k_nxt = k_q + 2'd1;
                if (last_pass) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            k_q    <= '0;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            cnt_q  <= cnt_nxt;
            op_q   <= op_nxt;
            k_q    <= k_nxt;
        end
    end

    assign in_ready  = (state == S_IDLE) && rst_n;
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_data  = data_q;

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle sequencer that time-shares a single shift stage to perform full 16-bit shifts and rotates of any amount 0–15. It accepts one request over a valid/ready handshake. It then applies shift-by-1, shift-by-2, shift-by-4 and shift-by-8 passes, one per cycle, for each set bit of the amount, and returns the result over a second valid/ready handshake. It sits in front of the ALU shift path, replacing a four-stage combinational barrel shifter when area matters more than latency.

## Interface

Parameters:
- SKIP_ZERO, default 1: 1 = stop after the highest set amount bit; 0 = always run 4 SHIFT cycles.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_data  in  16  operand
- in_cnt  in  4  shift/rotate amount
- in_op  in  2  operation: 00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_data  out  16  result
- busy  out  1  high in SHIFT or DONE

## Operation

- States: IDLE, SHIFT, DONE. Internal registers: data[15:0], cnt[3:0], op[1:0], stage index k[1:0].
- in_ready = (state == IDLE) && rst_n.
- busy = (state != IDLE).
- out_valid = (state == DONE).
- out_data = data register. The register is driven in all states and is meaningful only when out_valid is high.

IDLE:
- On in_valid && in_ready, capture in_data, in_cnt and in_op, and set k = 0.
- If in_cnt == 0, go to DONE. The data is unchanged.
- Otherwise, go to SHIFT.
- If in_valid is low, stay in IDLE. The registers hold.

SHIFT, one pass per cycle:
- If cnt[k] = 1, data <= stage(data, 2^k, op). Otherwise data holds.
- k increments each cycle.
- Exit to DONE after the pass at k = 3.
- When SKIP_ZERO = 1, also exit after the pass at k if cnt bits above k are all zero.
- Stage semantics for amount d:
  - ROL: bits leaving bit 15 re-enter at bit 0.
  - SLL: zero fill at the low end.
  - SRA: bit 15 replicated into the top d bits.
  - SRL: zero fill at the top.
- Composition of the passes equals a single shift/rotate by cnt (mod 16 for ROL).

DONE:
- out_data is held stable while out_valid && !out_ready.
- On out_valid && out_ready, go to IDLE.
- No new request is accepted in DONE; in_ready is 0.

Inputs are sampled only at acceptance. Changes to in_data, in_cnt or in_op after acceptance have no effect.

## Timing

- Reset (rst_n low at a rising edge) gives:
  - state = IDLE
  - data, cnt, op, k = 0
  - out_valid = 0, out_data = 0x0000, busy = 0
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after release.
- Reset mid-SHIFT or mid-DONE: the operation is abandoned and the result is never presented. The block returns to the state above on that edge.
- Let h be the index of the highest set bit of cnt. With SKIP_ZERO = 1:
  - The block is in SHIFT for h+1 cycles.
  - out_valid rises h+1 cycles after the acceptance edge.
  - cnt = 0 gives out_valid in the cycle immediately after acceptance.
- With SKIP_ZERO = 0, nonzero cnt always takes 4 SHIFT cycles.
- Throughput: with out_ready held high, the next in_ready is 1 in the cycle after the out handshake edge. There is no overlap between requests.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The input is accepted no earlier than the next cycle, in IDLE.
- Inside SHIFT, k wraps from 3 back to 0 only by leaving SHIFT.

## Test plan

- ROL 0x8001 by 4 (SKIP_ZERO = 1) -> 0x0018; out_valid 3 cycles after acceptance.
- SRA 0x8000 by 15 -> 0xFFFF after 4 SHIFT cycles; SRL 0x8000 by 15 -> 0x0001; SLL 0x00FF by 8 -> 0xFF00 with data unchanged in the k = 0..2 cycles.
- cnt = 0, any op, in_data 0xA5A5 -> out_data 0xA5A5, out_valid the cycle after acceptance, no SHIFT cycles.
- Backpressure: hold out_ready low 5 cycles in DONE.
  - out_data stays stable and out_valid stays high.
  - in_ready stays 0, and in_valid toggling is ignored.
  - Releasing out_ready completes the handshake, and in_ready = 1 the next cycle.
- Reset mid-SHIFT (ROL 0x1234 by 15, rst_n low on the 2nd SHIFT cycle):
  - Next cycle: out_valid = 0, out_data = 0x0000, busy = 0.
  - After release, a new request SLL 0x0001 by 3 -> 0x0008.
- SKIP_ZERO = 0, ROL 0x0001 by 1 -> 0x0002 with 4 SHIFT cycles. Random sweep of all ops, all 16 counts and random data is checked against a reference model.
